operand_sel_pipe: RTL and testbench

OPERAND_SEL_PIPE -- requirements
Module: operand_sel_pipe

---
 rtl/mips_pkg.sv | 16 +
 rtl/pipe_skid_buf.sv | 71 +++++++
 rtl/operand_sel_pipe.sv | 78 +++++++
 tb/tb_operand_sel_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared datapath widths and select-width helper
//
// Purpose : constants shared by the operand-select pipeline and its users.
//   DATA_W      operand data width
//   REG_ADDR_W  register-address width
//   sel_width() select width for n inputs, never less than 1 bit
package mips_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 2) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - two-entry MAIN/SKID register slice with valid/ready handshake
//
// Purpose : registers a stream with full throughput while keeping in_ready
//           purely registered (no path from out_ready to in_ready).
// Ports   :
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  synchronous discard of both entries
//   in_data/in_valid/in_ready     upstream side
//   out_data/out_valid/out_ready  downstream side (driven by MAIN)
module pipe_skid_buf #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] r_main_data;
    logic             r_main_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_valid;

    logic w_accept;
    logic w_xfer;

    // SKID full is the only back-pressure source, so in_ready is a flop output
    assign in_ready  = !r_skid_valid;
    assign out_data  = r_main_data;
    assign out_valid = r_main_valid;

    assign w_accept = in_valid && !r_skid_valid && !flush;
    assign w_xfer   = r_main_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_data  <= '0;
            r_main_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            // flush wins over any accept or transfer in the same cycle
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_xfer) begin
            if (r_skid_valid) begin
                // in_ready is low here, so no accept can collide with the move
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main_data  <= in_data;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_valid) begin
                r_main_data  <= in_data;
                r_main_valid <= 1'b1;
            end else begin
                r_skid_data  <= in_data;
                r_skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_sel_pipe.sv
// rtl/operand_sel_pipe.sv - registered N-way operand select with range check and skid buffer
//
// Purpose : selects one of NUM_IN packed inputs, flags out-of-range selects
//           with a sticky error, and registers the result through pipe_skid_buf.
// Ports   :
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_data                    NUM_IN packed inputs, input i at [i*WIDTH +: WIDTH]
//   sel                        binary select sampled with in_data
//   in_valid/in_ready          upstream handshake
//   flush                      discard held items and clear sel_err
//   out_data/out_valid/out_ready  downstream handshake
//   sel_err                    sticky: an out-of-range select was accepted
module operand_sel_pipe
    import mips_pkg::*;
#(
    parameter  int unsigned WIDTH  = DATA_W,
    parameter  int unsigned NUM_IN = 4,
    localparam int unsigned SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_ok;
    logic             w_in_ready;
    logic             w_accept;
    logic             r_sel_err;

    assign w_sel_ok = (32'(sel) < NUM_IN);
    assign w_accept = in_valid && w_in_ready && !flush;
    assign in_ready = w_in_ready;
    assign sel_err  = r_sel_err;

    // slice 0 is the fallback for any select that matches no input
    always_comb begin
        w_sel_data = in_data[WIDTH-1:0];
        for (int i = 1; i < int'(NUM_IN); i++) begin
            if (SEL_W'(i) == sel) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else if (flush) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && !w_sel_ok) begin
            r_sel_err <= 1'b1;
        end
    end

    pipe_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (w_sel_data),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_operand_sel_pipe.sv
// tb/tb_operand_sel_pipe.sv - self-checking bench for operand_sel_pipe
module tb_operand_sel_pipe;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // A: 32-bit, 4 inputs
    logic [127:0] a_in_data;
    logic [1:0]   a_sel;
    logic         a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_sel_err;
    logic [31:0]  a_out_data;
    // B: 32-bit, 3 inputs
    logic [95:0]  b_in_data;
    logic [1:0]   b_sel;
    logic         b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_sel_err;
    logic [31:0]  b_out_data;
    // C: 5-bit, 2 inputs
    logic [9:0]   c_in_data;
    logic [0:0]   c_sel;
    logic         c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready, c_sel_err;
    logic [4:0]   c_out_data;

    operand_sel_pipe #(.WIDTH(DATA_W), .NUM_IN(4)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .sel(a_sel), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .flush(a_flush), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .sel_err(a_sel_err));
    operand_sel_pipe #(.WIDTH(DATA_W), .NUM_IN(3)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .sel(b_sel), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .flush(b_flush), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .sel_err(b_sel_err));
    operand_sel_pipe #(.WIDTH(REG_ADDR_W), .NUM_IN(2)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .sel(c_sel), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .flush(c_flush), .out_data(c_out_data), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .sel_err(c_sel_err));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard model, one slot per DUT ----------------
    logic [31:0] sb_q [3][$];
    logic        err_m  [3];
    logic        hold_m [3];
    logic [31:0] hold_d [3];
    int          n_pop  [3];

    function automatic logic [31:0] pick(input logic [127:0] data, input int s, input int num, input int w);
        logic [127:0] sh;
        logic [31:0]  m;
        int           idx;
        idx = (s < num) ? s : 0;
        sh  = data >> (idx * w);
        m   = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return sh[31:0] & m;
    endfunction

    task automatic mon(input int d, input logic iv, input logic ir, input logic fl,
                       input logic ov, input logic ordy, input logic se, input logic [31:0] od,
                       input logic [127:0] data, input int s, input int num, input int w);
        int sz;
        string tag;
        tag = $sformatf("dut%0d", d);
        sz  = sb_q[d].size();
        chk({tag, "_out_valid"}, 32'(ov), 32'(sz > 0));
        chk({tag, "_in_ready"},  32'(ir), 32'(sz < 2));
        chk({tag, "_sel_err"},   32'(se), 32'(err_m[d]));
        if (sz > 0) chk({tag, "_out_data"}, od, sb_q[d][0]);
        if (hold_m[d] && ov) chk({tag, "_stable"}, od, hold_d[d]);
        hold_m[d] = ov && !ordy && !fl;
        hold_d[d] = od;
        if (fl) begin
            sb_q[d].delete();
            err_m[d] = 1'b0;
        end else begin
            if (sz > 0 && ordy) begin
                void'(sb_q[d].pop_front());
                n_pop[d]++;
            end
            if (iv && sz < 2) begin
                sb_q[d].push_back(pick(data, s, num, w));
                if (s >= num) err_m[d] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                sb_q[d].delete();
                err_m[d]  = 1'b0;
                hold_m[d] = 1'b0;
            end
        end else begin
            mon(0, a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_sel_err,
                a_out_data, a_in_data, int'(a_sel), 4, 32);
            mon(1, b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_sel_err,
                b_out_data, {32'd0, b_in_data}, int'(b_sel), 3, 32);
            mon(2, c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready, c_sel_err,
                32'(c_out_data), {118'd0, c_in_data}, int'(c_sel), 2, 5);
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        int          dut;
        logic [31:0] w0, w1, w2, w3;
        int          sel;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vt [8];

    task automatic apply_vec(input vec_t v, input int k);
        string tag;
        tag = $sformatf("vec%0d", k);
        if (v.dut == 0) begin
            a_out_ready = 1'b1;
            a_in_data   = {v.w3, v.w2, v.w1, v.w0};
            a_sel       = 2'(v.sel);
            a_in_valid  = 1'b1;
            step();
            a_in_valid = 1'b0;
            chk({tag, "_valid"}, 32'(a_out_valid), 32'd1);
            chk({tag, "_data"},  a_out_data, v.exp_data);
            chk({tag, "_err"},   32'(a_sel_err), 32'(v.exp_err));
            step();
            chk({tag, "_one_cycle"}, 32'(a_out_valid), 32'd0);
        end else begin
            b_out_ready = 1'b1;
            b_in_data   = {v.w2, v.w1, v.w0};
            b_sel       = 2'(v.sel);
            b_in_valid  = 1'b1;
            step();
            b_in_valid = 1'b0;
            chk({tag, "_valid"}, 32'(b_out_valid), 32'd1);
            chk({tag, "_data"},  b_out_data, v.exp_data);
            chk({tag, "_err"},   32'(b_sel_err), 32'(v.exp_err));
            step();
            chk({tag, "_one_cycle"}, 32'(b_out_valid), 32'd0);
        end
    endtask

    initial begin
        vt[0] = '{0, 32'd5, 32'd9, 32'd0, 32'd7, 1, 32'd9, 1'b0};
        vt[1] = '{0, 32'd5, 32'd9, 32'd0, 32'd7, 3, 32'd7, 1'b0};
        vt[2] = '{0, 32'hDEAD_BEEF, 32'd1, 32'd2, 32'd3, 0, 32'hDEAD_BEEF, 1'b0};
        vt[3] = '{0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 2, 32'hFFFF_FFFF, 1'b0};
        vt[4] = '{1, 32'h11, 32'h22, 32'h33, 32'd0, 3, 32'h11, 1'b1};
        vt[5] = '{1, 32'h11, 32'h22, 32'h33, 32'd0, 1, 32'h22, 1'b1};
        vt[6] = '{1, 32'h11, 32'h22, 32'h33, 32'd0, 2, 32'h33, 1'b1};
        vt[7] = '{1, 32'h44, 32'h55, 32'h66, 32'd0, 0, 32'h44, 1'b1};

        a_in_data = '0; a_sel = '0; a_in_valid = 0; a_flush = 0; a_out_ready = 0;
        b_in_data = '0; b_sel = '0; b_in_valid = 0; b_flush = 0; b_out_ready = 0;
        c_in_data = '0; c_sel = '0; c_in_valid = 0; c_flush = 0; c_out_ready = 0;

        // reset state
        repeat (3) step();
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data",  a_out_data, 32'd0);
        chk("rst_sel_err",   32'(b_sel_err), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready",  32'(a_in_ready), 32'd1);

        // table: mux slices, one-cycle latency, sticky range error
        for (int k = 0; k < 8; k++) apply_vec(vt[k], k);

        // back-pressure: A, B accepted, C held upstream, then drained in order
        a_out_ready = 1'b0;
        a_sel = 2'd0; a_in_data = {96'd0, 32'hA}; a_in_valid = 1'b1;
        step();
        chk("bp_ready_after_a", 32'(a_in_ready), 32'd1);
        a_in_data = {96'd0, 32'hB};
        step();
        chk("bp_ready_after_b", 32'(a_in_ready), 32'd0);
        chk("bp_head_a",        a_out_data, 32'hA);
        a_in_data = {96'd0, 32'hC};
        step();
        chk("bp_c_held",        32'(a_in_ready), 32'd0);
        chk("bp_head_stable",   a_out_data, 32'hA);
        a_out_ready = 1'b1;
        step();
        chk("bp_out_b",         a_out_data, 32'hB);
        chk("bp_out_b_valid",   32'(a_out_valid), 32'd1);
        step();
        a_in_valid = 1'b0;
        chk("bp_out_c",         a_out_data, 32'hC);
        chk("bp_out_c_valid",   32'(a_out_valid), 32'd1);
        step();
        chk("bp_empty",         32'(a_out_valid), 32'd0);

        // flush with both entries full (B has a sticky error set)
        b_out_ready = 1'b0;
        b_sel = 2'd1; b_in_data = {32'd0, 32'h71, 32'd0}; b_in_valid = 1'b1;
        step();
        b_in_data = {32'd0, 32'h72, 32'd0};
        step();
        chk("fl_full", 32'(b_in_ready), 32'd0);
        b_flush = 1'b1; b_in_data = {32'd0, 32'h73, 32'd0};
        step();
        b_flush = 1'b0; b_in_valid = 1'b0;
        chk("fl_out_valid", 32'(b_out_valid), 32'd0);
        chk("fl_sel_err",   32'(b_sel_err), 32'd0);
        chk("fl_in_ready",  32'(b_in_ready), 32'd1);
        b_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("fl_nothing_out", 32'(b_out_valid), 32'd0);
        end

        // asynchronous reset mid-transfer
        a_out_ready = 1'b0;
        a_sel = 2'd2; a_in_data = {32'd0, 32'h5A5A, 64'd0}; a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        chk("ar_pre_valid", 32'(a_out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid_now", 32'(a_out_valid), 32'd0);
        chk("ar_data_now",  a_out_data, 32'd0);
        #3 rst_n = 1'b1;
        a_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("ar_no_emit", 32'(a_out_valid), 32'd0);
        end

        // random traffic on the 5-bit, 2-input instance
        for (int k = 0; k < 1000; k++) begin
            c_in_valid  = ($urandom_range(0, 99) < 60);
            c_out_ready = ($urandom_range(0, 99) < 60);
            c_in_data   = 10'($urandom);
            c_sel       = 1'($urandom);
            step();
        end
        c_in_valid = 1'b0; c_out_ready = 1'b1;
        for (int k = 0; k < 10 && sb_q[2].size() != 0; k++) step();
        step();
        chk("rnd_drained", 32'(sb_q[2].size()), 32'd0);
        chk("rnd_traffic", 32'(n_pop[2] > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
